// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - multi-cycle STEP-bits-per-clock subtractor with start/busy/done handshake
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dif,
    output logic             bout,
    output logic             ovf
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] ra, rb, res, res_nx;
    logic             br, br_nx;
    logic [CW-1:0]    cnt;
    logic [STEP-1:0]  xs, ys, ds;
    logic             last, accept;
    int unsigned      base;

    assign last   = (cnt == CW'(N - 1));
    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // One slice of the borrow chain; the partial result lives in res until the final slice.
    always_comb begin
        base   = 32'(cnt) * STEP;
        xs     = ra[base +: STEP];
        ys     = rb[base +: STEP];
        br_nx  = br;
        ds     = '0;
        for (int i = 0; i < STEP; i++) begin
            ds[i] = xs[i] ^ ys[i] ^ br_nx;
            br_nx = (~xs[i] & ys[i]) | (~(xs[i] ^ ys[i]) & br_nx);
        end
        res_nx              = res;
        res_nx[base +: STEP] = ds;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            res  <= '0;
            dif  <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            ra  <= a;
            rb  <= b;
            br  <= bin;
            cnt <= '0;
            res <= '0;
        end else if (state == RUN) begin
            res <= res_nx;
            br  <= br_nx;
            cnt <= cnt + CW'(1);
            // Visible outputs move only when the whole word is finished.
            if (last) begin
                dif  <= res_nx;
                bout <= br_nx;
                ovf  <= (ra[WIDTH-1] != rb[WIDTH-1]) && (res_nx[WIDTH-1] != ra[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub (STEP=1 model, STEP=4/8 sweeps)
module tb_serial_sub;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       bin = 1'b0;
    logic       busy, done, bout, ovf;
    logic [7:0] dif;

    logic       s2 = 1'b0;
    logic [7:0] a2 = '0, b2 = '0;
    logic       bin2 = 1'b0;
    logic       busy4, done4, bout4, ovf4, busy8, done8, bout8, ovf8;
    logic [7:0] dif4, dif8;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .dif(dif), .bout(bout), .ovf(ovf));
    serial_sub #(.WIDTH(8), .STEP(4)) u4 (
        .clk(clk), .rst(rst), .start(s2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy4), .done(done4), .dif(dif4), .bout(bout4), .ovf(ovf4));
    serial_sub #(.WIDTH(8), .STEP(8)) u8 (
        .clk(clk), .rst(rst), .start(s2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy8), .done(done8), .dif(dif8), .bout(bout8), .ovf(ovf8));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, bout, dif} from plain unsigned and signed arithmetic.
    function automatic logic [9:0] golden(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] u;
        int s;
        u = {1'b0, x} - {1'b0, y} - 9'(c);
        s = int'($signed(x)) - int'($signed(y)) - int'(c);
        return {(s < -128 || s > 127), u};
    endfunction

    // Transaction-level model of the STEP=1 instance: an op occupies 8 busy cycles then one done cycle.
    int         m_rem = 0;
    logic       m_done = 1'b0;
    logic [9:0] m_res = '0;
    logic [9:0] m_lat = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else if (m_rem > 0) begin
            m_rem--;
            m_done = (m_rem == 0);
            if (m_rem == 0) m_res = m_lat;
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_lat = golden(a, b, bin);
                m_rem = 8;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, m_rem > 0);
            chk("done", done, m_done);
            chk("dif", dif, m_res[7:0]);
            chk("bout", bout, m_res[8]);
            chk("ovf", ovf, m_res[9]);
        end
    end

    task automatic op1(input logic [7:0] x, input logic [7:0] y, input logic c,
                       input logic [7:0] edif, input logic ebout, input logic eovf);
        int k, nb;
        @(negedge clk);
        a = x; b = y; bin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        k = 1; nb = int'(busy);
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
            nb += int'(busy);
        end
        chk("lat1", k, 9);
        chk("busycnt1", nb, 8);
        chk("lit_res", {ovf, bout, dif}, {eovf, ebout, edif});
    endtask

    task automatic op48(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [9:0] g;
        g = golden(x, y, c);
        @(negedge clk);
        a2 = x; b2 = y; bin2 = c; s2 = 1'b1;
        @(negedge clk);
        s2 = 1'b0; a2 = ~x; b2 = ~y; bin2 = ~c;
        chk("busy48", {busy4, busy8, done4, done8}, 4'b1100);
        @(negedge clk);
        chk("s8", {busy8, done8, ovf8, bout8, dif8}, {2'b01, g[9], g[8], g[7:0]});
        chk("busy4b", {busy4, done4}, 2'b10);
        @(negedge clk);
        chk("s4", {busy4, done4, ovf4, bout4, dif4}, {2'b01, g[9], g[8], g[7:0]});
    endtask

    initial begin
        int k, nb;
        logic [7:0] corners [8];
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55};

        chk("g_05_03", golden(8'h05, 8'h03, 1'b0), 10'h002);
        chk("g_03_05", golden(8'h03, 8'h05, 1'b0), 10'h1FE);
        chk("g_80_00b", golden(8'h80, 8'h00, 1'b1), 10'h27F);
        chk("g_7f_ff", golden(8'h7F, 8'hFF, 1'b0), 10'h380);

        repeat (3) @(negedge clk);
        chk("rst_out", {busy, done, bout, ovf, dif}, 12'h000);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("idle_out", {busy, done, bout, ovf, dif}, 12'h000);

        op1(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        op1(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        op1(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        op1(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op1(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        op1(8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1);

        // start held through RUN, then a back-to-back op taken from DONE
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        end
        @(negedge clk);
        chk("hold_done", done, 1'b1);
        chk("hold_res", {ovf, bout, dif}, 10'h00F);
        a = 8'h20; b = 8'h22; bin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        k = 1; nb = 1;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
            nb += int'(busy);
        end
        chk("b2b_lat", k, 9);
        chk("b2b_res", {ovf, bout, dif}, 10'h1FD);

        // async reset in the middle of RUN
        @(negedge clk);
        a = 8'h44; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("arst_out", {busy, done, bout, ovf, dif}, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        op1(8'h44, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);

        // random traffic, start sometimes held, checked cycle by cycle against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            start = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        foreach (corners[i]) begin
            for (int y = 0; y < 256; y++) begin
                op48(corners[i], 8'(y), 1'b0);
                op48(corners[i], 8'(y), 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
